// File: rtl/compare_cascade.sv
// compare_cascade: folds an MSB-first stream of per-digit G/E/L flags into a
// single word-level A>B / A==B / A<B result. The first legal non-equal digit
// decides the word, malformed digits and overlong words raise a sticky error,
// and each result is held until the consumer accepts it.
module compare_cascade #(
  parameter int MAX_DIGITS = 8,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_g,
  input  logic          in_e,
  input  logic          in_l,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          res_g,
  output logic          res_e,
  output logic          res_l,
  output logic [CW-1:0] res_digits,
  output logic          res_err
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Word decision: nothing decided yet, A>B, or A<B.
  typedef enum logic [1:0] {
    DEC_NONE = 2'b00,
    DEC_G    = 2'b01,
    DEC_L    = 2'b10
  } dec_t;

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  // A digit is legal only when exactly one of its three flags is set.
  function automatic logic is_onehot3(input logic [2:0] flags);
    is_onehot3 = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  endfunction

  state_t        state_r, state_nxt_s;
  dec_t          dec_r, dec_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          err_r, err_nxt_s;
  logic          res_g_r, res_e_r, res_l_r, res_err_r;
  logic [CW-1:0] res_digits_r;
  logic          res_g_nxt_s, res_e_nxt_s, res_l_nxt_s, res_err_nxt_s;
  logic [CW-1:0] res_digits_nxt_s;
  logic          legal_s, full_s;
  dec_t          dig_dec_s;
  logic [CW-1:0] dig_cnt_s;
  logic          dig_err_s;

  // Per-digit view: what the accumulators become if the presented digit is taken.
  always_comb begin
    legal_s   = is_onehot3({in_g, in_e, in_l});
    full_s    = (cnt_r == CNT_MAX);
    dig_dec_s = dec_r;
    dig_cnt_s = cnt_r;
    dig_err_s = err_r | ~legal_s | full_s;
    if (full_s) begin
      dig_cnt_s = cnt_r;
    end else begin
      dig_cnt_s = cnt_r + CNT_ONE;
    end
    if ((dec_r == DEC_NONE) && legal_s && !full_s && !in_e) begin
      dig_dec_s = in_g ? DEC_G : DEC_L;
    end else begin
      dig_dec_s = dec_r;
    end
  end

  // Next-state and next-result logic for the ACC/HOLD controller.
  always_comb begin
    state_nxt_s      = state_r;
    dec_nxt_s        = dec_r;
    cnt_nxt_s        = cnt_r;
    err_nxt_s        = err_r;
    res_g_nxt_s      = res_g_r;
    res_e_nxt_s      = res_e_r;
    res_l_nxt_s      = res_l_r;
    res_digits_nxt_s = res_digits_r;
    res_err_nxt_s    = res_err_r;
    case (state_r)
      ACC: begin
        if (in_valid) begin
          dec_nxt_s = dig_dec_s;
          cnt_nxt_s = dig_cnt_s;
          err_nxt_s = dig_err_s;
          if (in_last) begin
            state_nxt_s      = HOLD;
            res_g_nxt_s      = (dig_dec_s == DEC_G);
            res_l_nxt_s      = (dig_dec_s == DEC_L);
            res_e_nxt_s      = (dig_dec_s == DEC_NONE);
            res_digits_nxt_s = dig_cnt_s;
            res_err_nxt_s    = dig_err_s;
          end else begin
            state_nxt_s = ACC;
          end
        end else begin
          state_nxt_s = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s      = ACC;
          dec_nxt_s        = DEC_NONE;
          cnt_nxt_s        = CNT_ZERO;
          err_nxt_s        = 1'b0;
          res_g_nxt_s      = 1'b0;
          res_e_nxt_s      = 1'b0;
          res_l_nxt_s      = 1'b0;
          res_digits_nxt_s = CNT_ZERO;
          res_err_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s      = ACC;
        dec_nxt_s        = DEC_NONE;
        cnt_nxt_s        = CNT_ZERO;
        err_nxt_s        = 1'b0;
        res_g_nxt_s      = 1'b0;
        res_e_nxt_s      = 1'b0;
        res_l_nxt_s      = 1'b0;
        res_digits_nxt_s = CNT_ZERO;
        res_err_nxt_s    = 1'b0;
      end
    endcase
  end

  // State, accumulator and result registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ACC;
      dec_r        <= DEC_NONE;
      cnt_r        <= CNT_ZERO;
      err_r        <= 1'b0;
      res_g_r      <= 1'b0;
      res_e_r      <= 1'b0;
      res_l_r      <= 1'b0;
      res_digits_r <= CNT_ZERO;
      res_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dec_r        <= dec_nxt_s;
      cnt_r        <= cnt_nxt_s;
      err_r        <= err_nxt_s;
      res_g_r      <= res_g_nxt_s;
      res_e_r      <= res_e_nxt_s;
      res_l_r      <= res_l_nxt_s;
      res_digits_r <= res_digits_nxt_s;
      res_err_r    <= res_err_nxt_s;
    end
  end

  // Handshake flags come straight from the state register, so there is no
  // combinational path from out_ready to in_ready.
  always_comb begin
    in_ready   = (state_r == ACC);
    out_valid  = (state_r == HOLD);
    res_g      = res_g_r;
    res_e      = res_e_r;
    res_l      = res_l_r;
    res_digits = res_digits_r;
    res_err    = res_err_r;
  end

endmodule

// File: tb/tb_compare_cascade.sv
// Self-checking bench for compare_cascade: directed scenarios plus random
// words, each checked against a word-level reference model.
module tb_compare_cascade;

  localparam int MAXD = 8;
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [2:0] DG = 3'b100;
  localparam logic [2:0] DE = 3'b010;
  localparam logic [2:0] DL = 3'b001;
  localparam logic [2:0] DBAD = 3'b110;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic          in_g, in_e, in_l, in_last;
  logic          out_valid, out_ready;
  logic          res_g, res_e, res_l, res_err;
  logic [CW-1:0] res_digits;

  compare_cascade #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_g(in_g), .in_e(in_e), .in_l(in_l), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_g(res_g), .res_e(res_e), .res_l(res_l),
    .res_digits(res_digits), .res_err(res_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] wd_q[$];
  logic       exp_g, exp_e, exp_l, exp_err;
  int         exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: only digits arriving while fewer than MAXD were counted can
  // decide; the first legal G or L wins; any illegal or overflow digit errs.
  task automatic model();
    int dec;
    dec = 0;
    exp_err = 1'b0;
    for (int i = 0; i < wd_q.size(); i++) begin
      if ($countones(wd_q[i]) != 1) exp_err = 1'b1;
      if (i >= MAXD) exp_err = 1'b1;
      else if (dec == 0 && $countones(wd_q[i]) == 1 && wd_q[i] != DE)
        dec = (wd_q[i] == DG) ? 1 : 2;
    end
    exp_cnt = (wd_q.size() > MAXD) ? MAXD : wd_q.size();
    exp_g = (dec == 1);
    exp_l = (dec == 2);
    exp_e = (dec == 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_ir"}, in_ready, 1);
    check({tag, "_g"}, res_g, 0);
    check({tag, "_e"}, res_e, 0);
    check({tag, "_l"}, res_l, 0);
    check({tag, "_cnt"}, res_digits, 0);
    check({tag, "_err"}, res_err, 0);
  endtask

  task automatic check_res(input string tag);
    check({tag, "_ov"}, out_valid, 1);
    check({tag, "_ir"}, in_ready, 0);
    check({tag, "_g"}, res_g, exp_g);
    check({tag, "_e"}, res_e, exp_e);
    check({tag, "_l"}, res_l, exp_l);
    check({tag, "_cnt"}, res_digits, exp_cnt);
    check({tag, "_err"}, res_err, exp_err);
  endtask

  // Called at a falling edge; presents one digit after optional idle cycles
  // carrying junk flags, and returns at the falling edge after acceptance.
  task automatic drive_digit(input logic [2:0] d, input logic last, input int maxgap);
    int gap;
    gap = $urandom_range(maxgap, 0);
    repeat (gap) begin
      in_valid = 1'b0;
      {in_g, in_e, in_l} = 3'($urandom);
      in_last = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    {in_g, in_e, in_l} = d;
    in_last = last;
    check("acc_ir", in_ready, 1);
    check("acc_ov", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_partial(input int n, input int maxgap);
    for (int i = 0; i < n; i++) drive_digit(wd_q[i], 1'b0, maxgap);
  endtask

  // Sends the whole word in wd_q and checks the result one cycle later.
  task automatic run_word(input int maxgap);
    model();
    for (int i = 0; i < wd_q.size(); i++)
      drive_digit(wd_q[i], (i == wd_q.size() - 1), maxgap);
    check_res("res");
  endtask

  // Stalls the consumer, feeding ignored digits, then completes the handshake.
  task automatic finish_hold(input int hold);
    repeat (hold) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      {in_g, in_e, in_l} = 3'($urandom);
      in_last = 1'b1;
      @(negedge clk);
      check_res("hold");
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_ov", out_valid, 0);
    check("post_ir", in_ready, 1);
    out_ready = 1'b0;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] rand_digit();
    int r;
    logic [2:0] bad [5];
    bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    r = $urandom_range(9, 0);
    if (r == 5) return DG;
    else if (r == 6) return DL;
    else if (r == 7) return bad[$urandom_range(4, 0)];
    else return DE;
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_g = 1'b0; in_e = 1'b0; in_l = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    wd_q = '{DE, DE, DG};               run_word(0); finish_hold(0);
    wd_q = '{DL, DG, DG, DE};           run_word(1); finish_hold(1);
    wd_q = '{DE, DE, DE, DE, DE, DE, DE, DE};      run_word(0); finish_hold(0);
    wd_q = '{DE, DE, DE, DE, DE, DE, DE, DE, DG};  run_word(0); finish_hold(0);
    wd_q = '{DE, DBAD, DG};             run_word(0); finish_hold(0);
    wd_q = '{DL};                       run_word(0); finish_hold(0);
    wd_q = '{DG, DL};                   run_word(0); finish_hold(5);
    wd_q = '{DE, DL};                   run_word(0); finish_hold(0);

    // Abort mid-word, then a clean word must show no residue.
    wd_q = '{DG, DE, DL, DE};           send_partial(2, 0); pulse_reset();
    wd_q = '{DL, DE, DE, DG};           run_word(0); finish_hold(0);
    // Abort a held result; it must never be delivered.
    wd_q = '{DE, DG};                   run_word(0); pulse_reset();
    wd_q = '{DE, DE, DE};               run_word(0); finish_hold(2);

    for (int w = 0; w < 60; w++) begin
      int len;
      len = $urandom_range(11, 1);
      wd_q.delete();
      for (int i = 0; i < len; i++) wd_q.push_back(rand_digit());
      run_word(2);
      finish_hold($urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
